// File: rtl/bram_stream_reader_if.sv
// bram_stream_reader_if
//   Groups the block RAM port and the outgoing valid/ready stream of the
//   bram_stream_reader into one bundle.
//   master modport : the reader (drives RAM address/controls and stream data)
//   slave modport  : the environment (RAM model and stream consumer)
//   Signals:
//     bram_addr  RAM port address            (master -> slave)
//     bram_we    RAM write enable, always 0  (master -> slave)
//     bram_din   RAM write data, always 0    (master -> slave)
//     bram_dout  RAM read data, one cycle after address capture (slave -> master)
//     m_data     stream data                 (master -> slave)
//     m_valid    stream valid                (master -> slave)
//     m_last     final beat marker           (master -> slave)
//     m_ready    stream ready                (slave -> master)
interface bram_stream_reader_if #(
  parameter int DATA_W = 256,
  parameter int ADDR_W = 10
);
  logic [ADDR_W-1:0] bram_addr;
  logic              bram_we;
  logic [DATA_W-1:0] bram_din;
  logic [DATA_W-1:0] bram_dout;
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;
  logic              m_last;

  modport master (
    output bram_addr, bram_we, bram_din, m_data, m_valid, m_last,
    input  bram_dout, m_ready
  );

  modport slave (
    input  bram_addr, bram_we, bram_din, m_data, m_valid, m_last,
    output bram_dout, m_ready
  );
endinterface

// File: rtl/bram_stream_reader.sv
// bram_stream_reader
//   Read-side master for one port of a 2^ADDR_W x DATA_W block RAM. On an
//   accepted start it reads a contiguous (modulo-depth) address range, absorbs
//   the RAM's one-cycle read latency and presents the words as a valid/ready
//   stream with full throughput and lossless backpressure.
//   Ports:
//     clk        clock for the block and the attached RAM port
//     rstn       asynchronous active-low reset
//     start      command strobe, only sampled while idle
//     base_addr  first word address
//     length     word count 0..2^ADDR_W (larger values clamp to 2^ADDR_W)
//     busy       transfer in progress
//     done       one-cycle pulse after the final beat is accepted
//     bus        RAM port + output stream (master modport)
module bram_stream_reader #(
  parameter int DATA_W = 256,
  parameter int ADDR_W = 10
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    base_addr,
  input  logic [ADDR_W:0]      length,
  output logic                 busy,
  output logic                 done,
  bram_stream_reader_if.master bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0] addr_hold_q;
  logic [ADDR_W:0]   issue_cnt_q, issue_cnt_d;
  logic [ADDR_W:0]   beat_cnt_q, beat_cnt_d;
  logic              inflight_q;
  logic [DATA_W-1:0] fifo_q [3];
  logic [1:0]        wr_ptr_q, rd_ptr_q, count_q;
  logic [ADDR_W:0]   len_clamped;
  logic              issue, push, pop;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  assign len_clamped = (length > MAX_LEN) ? MAX_LEN : length;

  // Credit check uses only registered state, so m_ready never reaches
  // bram_addr combinationally. Buffered plus in-flight words stay <= 3,
  // which is exactly the FIFO depth.
  assign issue = (state_q == S_RUN) && (issue_cnt_q != '0) &&
                 (({1'b0, count_q} + {2'b00, inflight_q}) < 3'd3);
  assign push  = inflight_q;
  assign pop   = bus.m_valid && bus.m_ready;

  // Address is presented combinationally in the issue cycle so the RAM
  // captures it at the following edge; otherwise the last issued address holds.
  assign bus.bram_addr = issue ? rd_addr_q : addr_hold_q;
  assign bus.bram_we   = 1'b0;
  assign bus.bram_din  = '0;

  assign bus.m_valid = (count_q != 2'd0);
  assign bus.m_data  = bus.m_valid ? fifo_q[rd_ptr_q] : '0;
  assign bus.m_last  = bus.m_valid && (beat_cnt_q == CNT_ONE);

  assign busy = (state_q == S_RUN) || (state_q == S_FLUSH);
  assign done = (state_q == S_DONE);

  always_comb begin
    state_d     = state_q;
    rd_addr_d   = rd_addr_q;
    issue_cnt_d = issue_cnt_q;
    beat_cnt_d  = beat_cnt_q;
    if (pop) begin
      beat_cnt_d = beat_cnt_q - CNT_ONE;
    end
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          rd_addr_d   = base_addr;
          issue_cnt_d = len_clamped;
          beat_cnt_d  = len_clamped;
          state_d     = (len_clamped == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (issue) begin
          rd_addr_d   = rd_addr_q + 1'b1;
          issue_cnt_d = issue_cnt_q - CNT_ONE;
          if (issue_cnt_q == CNT_ONE) begin
            state_d = S_FLUSH;
          end
        end
      end
      S_FLUSH: begin
        // Leaving on the final pop makes done appear in the very next cycle.
        if ((pop && (beat_cnt_q == CNT_ONE)) || (beat_cnt_q == '0)) begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      rd_addr_q   <= '0;
      addr_hold_q <= '0;
      issue_cnt_q <= '0;
      beat_cnt_q  <= '0;
      inflight_q  <= 1'b0;
      wr_ptr_q    <= 2'd0;
      rd_ptr_q    <= 2'd0;
      count_q     <= 2'd0;
    end else begin
      state_q     <= state_d;
      rd_addr_q   <= rd_addr_d;
      issue_cnt_q <= issue_cnt_d;
      beat_cnt_q  <= beat_cnt_d;
      inflight_q  <= issue;
      if (issue) begin
        addr_hold_q <= rd_addr_q;
      end
      if (push) begin
        wr_ptr_q <= ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  // FIFO storage carries data only; m_data is gated by m_valid, so it needs no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= bus.bram_dout;
    end
  end

endmodule

// File: tb/tb_bram_stream_reader.sv
// tb_bram_stream_reader
//   Directed bench for bram_stream_reader with a registered-read RAM model.
//   RAM word at address a holds pat(a), so every expected beat is known
//   from its address alone.
module tb_bram_stream_reader;
  localparam int DATA_W = 256;
  localparam int ADDR_W = 10;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic [9:0]  base_addr = '0;
  logic [10:0] length = '0;
  logic        busy;
  logic        done;

  int checks = 0;
  int failures = 0;

  bram_stream_reader_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  bram_stream_reader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .busy      (busy),
    .done      (done),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  logic [255:0] mem [1024];
  always @(posedge clk) bus.bram_dout <= mem[bus.bram_addr];

  function automatic logic [255:0] pat(input logic [9:0] a);
    return {a, 6'h0, 16'hBEEF, 198'h0, ~a, 6'h0, a};
  endfunction

  // Observations gathered by collect()
  logic [255:0] got_data[$];
  bit           got_last[$];
  int first_valid, done_cycle, done_cnt, last_hs, stall_err, ahead_err;
  bit busy_c0, busy_at_done, busy_after;

  task automatic start_xfer(input logic [9:0] b, input logic [10:0] l);
    start = 1'b1;
    base_addr = b;
    length = l;
    @(posedge clk); #1;
    start = 1'b0;
    base_addr = 10'h155;
    length = 11'h7FF;
  endtask

  // Called at #1 after the edge that accepted start; cycle 0 is that cycle.
  task automatic collect(input logic [9:0] b, input int ready_pct,
                         input int inject_at, input int budget);
    bit           prev_stall;
    logic [255:0] prev_data;
    bit           prev_last;
    int           accepted;
    logic [9:0]   diff;
    got_data.delete();
    got_last.delete();
    first_valid = -1; done_cycle = -1; done_cnt = 0; last_hs = -1;
    stall_err = 0; ahead_err = 0; busy_c0 = 0; busy_at_done = 0; busy_after = 0;
    prev_stall = 0; prev_data = '0; prev_last = 0; accepted = 0;
    for (int c = 0; c < budget; c++) begin
      bus.m_ready = ($urandom_range(99) < ready_pct);
      if (c == inject_at) begin
        start = 1'b1; base_addr = 10'h300; length = 11'd3;
      end else if (c == inject_at + 1) begin
        start = 1'b0;
      end
      if (prev_stall && (!bus.m_valid || bus.m_data !== prev_data || bus.m_last !== prev_last))
        stall_err++;
      diff = bus.bram_addr - b;
      if (busy && (int'(diff) > accepted + 2)) ahead_err++;
      if (c == 0) busy_c0 = busy;
      if (bus.m_valid && first_valid < 0) first_valid = c;
      if (bus.m_valid && bus.m_ready) begin
        got_data.push_back(bus.m_data);
        got_last.push_back(bus.m_last);
        accepted++;
        last_hs = c;
      end
      if (done) begin
        done_cnt++;
        if (done_cycle < 0) begin
          done_cycle = c;
          busy_at_done = busy;
        end
      end
      if (done_cycle >= 0 && c > done_cycle && busy) busy_after = 1;
      prev_stall = bus.m_valid && !bus.m_ready;
      prev_data = bus.m_data;
      prev_last = bus.m_last;
      if (done_cycle >= 0 && c >= done_cycle + 3) break;
      @(posedge clk); #1;
    end
    bus.m_ready = 1'b0;
    start = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    bus.m_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy actual=%0b expected=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done actual=%0b expected=0", done); end
    checks++; if (bus.m_valid !== 1'b0) begin failures++; $display("FAIL reset_m_valid actual=%0b expected=0", bus.m_valid); end
    checks++; if (bus.m_last !== 1'b0) begin failures++; $display("FAIL reset_m_last actual=%0b expected=0", bus.m_last); end
    checks++; if (bus.m_data !== 256'h0) begin failures++; $display("FAIL reset_m_data actual=%h expected=0", bus.m_data); end
    checks++; if (bus.bram_addr !== 10'h0) begin failures++; $display("FAIL reset_bram_addr actual=%h expected=0", bus.bram_addr); end
    checks++; if (bus.bram_we !== 1'b0) begin failures++; $display("FAIL reset_bram_we actual=%0b expected=0", bus.bram_we); end
    checks++; if (bus.bram_din !== 256'h0) begin failures++; $display("FAIL reset_bram_din actual=%h expected=0", bus.bram_din); end
    rstn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    start_xfer(10'h010, 11'd4);
    collect(10'h010, 100, -1, 50);
    checks++; if (got_data.size() != 4) begin failures++; $display("FAIL basic_beats actual=%0d expected=4", got_data.size()); end
    for (int i = 0; i < got_data.size() && i < 4; i++) begin
      checks++; if (got_data[i] !== pat(10'(16 + i))) begin failures++; $display("FAIL basic_data[%0d] actual=%h expected=%h", i, got_data[i], pat(10'(16 + i))); end
      checks++; if (got_last[i] !== (i == 3)) begin failures++; $display("FAIL basic_last[%0d] actual=%0b expected=%0b", i, got_last[i], (i == 3)); end
    end
    checks++; if (first_valid != 2) begin failures++; $display("FAIL basic_first_valid actual=%0d expected=2", first_valid); end
    checks++; if (last_hs != 5) begin failures++; $display("FAIL basic_last_handshake actual=%0d expected=5", last_hs); end
    checks++; if (done_cycle != 6) begin failures++; $display("FAIL basic_done_cycle actual=%0d expected=6", done_cycle); end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL basic_done_count actual=%0d expected=1", done_cnt); end
    checks++; if (busy_c0 !== 1'b1) begin failures++; $display("FAIL basic_busy_start actual=%0b expected=1", busy_c0); end
    checks++; if (busy_at_done !== 1'b0) begin failures++; $display("FAIL basic_busy_at_done actual=%0b expected=0", busy_at_done); end
  endtask

  task automatic test_wrap();
    logic [9:0] exp_addr [4];
    exp_addr = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
    start_xfer(10'h3FE, 11'd4);
    collect(10'h3FE, 100, -1, 50);
    checks++; if (got_data.size() != 4) begin failures++; $display("FAIL wrap_beats actual=%0d expected=4", got_data.size()); end
    for (int i = 0; i < got_data.size() && i < 4; i++) begin
      checks++; if (got_data[i] !== pat(exp_addr[i])) begin failures++; $display("FAIL wrap_data[%0d] actual=%h expected=%h", i, got_data[i], pat(exp_addr[i])); end
    end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL wrap_done_count actual=%0d expected=1", done_cnt); end
  endtask

  task automatic test_backpressure();
    int nlast;
    start_xfer(10'h100, 11'd16);
    collect(10'h100, 50, -1, 600);
    checks++; if (got_data.size() != 16) begin failures++; $display("FAIL bp_beats actual=%0d expected=16", got_data.size()); end
    nlast = 0;
    for (int i = 0; i < got_data.size() && i < 16; i++) begin
      if (got_last[i]) nlast++;
      checks++; if (got_data[i] !== pat(10'(256 + i))) begin failures++; $display("FAIL bp_data[%0d] actual=%h expected=%h", i, got_data[i], pat(10'(256 + i))); end
    end
    checks++; if (nlast != 1 || got_last.size() != 16 || got_last[15] !== 1'b1) begin failures++; $display("FAIL bp_last actual_count=%0d expected_count=1 on beat 16", nlast); end
    checks++; if (stall_err != 0) begin failures++; $display("FAIL bp_stall_stable actual=%0d expected=0", stall_err); end
    checks++; if (ahead_err != 0) begin failures++; $display("FAIL bp_issue_ahead actual=%0d expected=0", ahead_err); end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL bp_done_count actual=%0d expected=1", done_cnt); end
  endtask

  task automatic test_len0();
    start_xfer(10'h123, 11'd0);
    collect(10'h123, 100, -1, 10);
    checks++; if (done_cycle != 0) begin failures++; $display("FAIL len0_done_cycle actual=%0d expected=0", done_cycle); end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL len0_done_count actual=%0d expected=1", done_cnt); end
    checks++; if (first_valid != -1) begin failures++; $display("FAIL len0_valid actual=%0d expected=-1", first_valid); end
    checks++; if (busy_c0 !== 1'b0) begin failures++; $display("FAIL len0_busy actual=%0b expected=0", busy_c0); end
  endtask

  task automatic test_len_full(input logic [9:0] b, input logic [10:0] l);
    int bad, nlast;
    start_xfer(b, l);
    collect(b, 100, -1, 1100);
    bad = 0; nlast = 0;
    for (int i = 0; i < got_data.size(); i++) begin
      if (got_data[i] !== pat(10'(int'(b) + i))) bad++;
      if (got_last[i]) nlast++;
    end
    checks++; if (got_data.size() != 1024) begin failures++; $display("FAIL full%0d_beats actual=%0d expected=1024", l, got_data.size()); end
    checks++; if (bad != 0) begin failures++; $display("FAIL full%0d_data bad_beats=%0d expected=0", l, bad); end
    checks++; if (nlast != 1 || got_last.size() != 1024 || got_last[1023] !== 1'b1) begin failures++; $display("FAIL full%0d_last actual_count=%0d expected_count=1 on beat 1024", l, nlast); end
    checks++; if (done_cycle != 1026) begin failures++; $display("FAIL full%0d_done_cycle actual=%0d expected=1026", l, done_cycle); end
  endtask

  task automatic test_start_busy();
    start_xfer(10'h040, 11'd8);
    collect(10'h040, 100, 3, 60);
    checks++; if (got_data.size() != 8) begin failures++; $display("FAIL sbusy_beats actual=%0d expected=8", got_data.size()); end
    for (int i = 0; i < got_data.size() && i < 8; i++) begin
      checks++; if (got_data[i] !== pat(10'(64 + i))) begin failures++; $display("FAIL sbusy_data[%0d] actual=%h expected=%h", i, got_data[i], pat(10'(64 + i))); end
    end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL sbusy_done_count actual=%0d expected=1", done_cnt); end
    checks++; if (done_cycle != 10) begin failures++; $display("FAIL sbusy_done_cycle actual=%0d expected=10", done_cycle); end
    checks++; if (busy_after !== 1'b0) begin failures++; $display("FAIL sbusy_restart actual=%0b expected=0", busy_after); end
  endtask

  task automatic test_reset_mid();
    int hs;
    start_xfer(10'h000, 11'd8);
    bus.m_ready = 1'b1;
    hs = 0;
    for (int c = 0; c < 20 && hs < 3; c++) begin
      if (bus.m_valid && bus.m_ready) hs++;
      @(posedge clk); #1;
    end
    checks++; if (hs != 3) begin failures++; $display("FAIL rmid_beats_before_reset actual=%0d expected=3", hs); end
    rstn = 1'b0;
    #1;
    checks++; if (bus.m_valid !== 1'b0) begin failures++; $display("FAIL rmid_m_valid actual=%0b expected=0", bus.m_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rmid_busy actual=%0b expected=0", busy); end
    checks++; if (bus.m_data !== 256'h0) begin failures++; $display("FAIL rmid_m_data actual=%h expected=0", bus.m_data); end
    bus.m_ready = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    start_xfer(10'h000, 11'd2);
    collect(10'h000, 100, -1, 20);
    checks++; if (got_data.size() != 2) begin failures++; $display("FAIL rmid_after_beats actual=%0d expected=2", got_data.size()); end
    for (int i = 0; i < got_data.size() && i < 2; i++) begin
      checks++; if (got_data[i] !== pat(10'(i))) begin failures++; $display("FAIL rmid_after_data[%0d] actual=%h expected=%h", i, got_data[i], pat(10'(i))); end
    end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL rmid_after_done_count actual=%0d expected=1", done_cnt); end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = pat(10'(i));
    bus.m_ready = 1'b0;
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_len0();
    test_len_full(10'h200, 11'd1024);
    test_len_full(10'h000, 11'd2000);
    test_start_busy();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
